usr_serializer_ctrl: RTL and testbench



---
 rtl/usr_serializer_ctrl_pkg.sv | 17 +
 rtl/usr_serializer_ctrl.sv | 138 +++++++++++++
 tb/tb_usr_serializer_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usr_serializer_ctrl_pkg.sv
// Shared definitions for the universal shift register and its serializer
// controller: the register mode encoding and the controller state type.
package usr_serializer_ctrl_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/usr_serializer_ctrl.sv
// Parallel-to-serial sequencing controller for an external universal shift
// register. Accepts a word over valid/ready, parallel-loads it into the
// register, then drives WIDTH shift cycles and presents the outgoing end bit
// as a qualified serial stream, optionally followed by GAP_CYCLES idle cycles.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    word handshake; in_data word, msb_first direction
//   flush                synchronous abort of the word in flight
//   sr_mode, sr_din      mode and parallel-load data to the register
//   sr_dout              register contents (end bits feed ser_bit)
//   ser_bit, ser_valid   serial output and its qualifier
//   busy, done           word in flight; pulse with the last bit
//
// state    | meaning
// ST_IDLE  | ready for a word, register held
// ST_LOAD  | register loads sr_din this cycle
// ST_SHIFT | one bit out per cycle, WIDTH cycles
// ST_GAP   | GAP_CYCLES idle cycles before the next word
module usr_serializer_ctrl
  import usr_serializer_ctrl_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  input  logic             flush,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_din,
  input  logic [WIDTH-1:0] sr_dout,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  // Gap counter counts down to zero; it is preloaded with GAP_CYCLES-1 so that
  // the GAP state lasts exactly GAP_CYCLES cycles.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             dir_q, dir_d;
  logic             unused_dout;

  // Only the two end bits of the register are observed.
  assign unused_dout = ^sr_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      din_q   <= '0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      din_q   <= din_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    din_d   = din_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          din_d   = in_data;
          dir_d   = msb_first;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush in IDLE is ignored so a simultaneous acceptance still goes through.
    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      gap_d   = '0;
    end
  end

  always_comb begin
    sr_mode = MODE_HOLD;
    case (state_q)
      ST_LOAD:  sr_mode = MODE_LOAD;
      ST_SHIFT: sr_mode = dir_q ? MODE_SHL : MODE_SHR;
      default:  sr_mode = MODE_HOLD;
    endcase
  end

  assign sr_din    = din_q;
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_bit   = dir_q ? sr_dout[WIDTH-1] : sr_dout[0];
  // Decoded from the count alone, so a flush on the last bit still reports done.
  assign done      = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_usr_serializer_ctrl.sv
module tb_usr_serializer_ctrl;
  import usr_serializer_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int G1 = 3;

  logic clk = 1'b0;
  logic rst;
  logic       in_valid [2];
  logic       in_ready [2];
  logic       msb_first[2];
  logic       flush    [2];
  logic       ser_bit  [2];
  logic       ser_valid[2];
  logic       busy     [2];
  logic       done     [2];
  logic [W-1:0] in_data[2];
  logic [W-1:0] sr_din [2];
  logic [W-1:0] sr_dout[2];
  logic [1:0]   sr_mode[2];

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int t_acc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Behavioural universal shift register, serial fill 0.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      case (sr_mode[i])
        MODE_SHR:  sr_dout[i] <= {1'b0, sr_dout[i][W-1:1]};
        MODE_SHL:  sr_dout[i] <= {sr_dout[i][W-2:0], 1'b0};
        MODE_LOAD: sr_dout[i] <= sr_din[i];
        default:   sr_dout[i] <= sr_dout[i];
      endcase
    end
  end

  usr_serializer_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .msb_first(msb_first[0]), .flush(flush[0]),
    .sr_mode(sr_mode[0]), .sr_din(sr_din[0]), .sr_dout(sr_dout[0]),
    .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]), .busy(busy[0]), .done(done[0]));

  usr_serializer_ctrl #(.WIDTH(W), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .msb_first(msb_first[1]), .flush(flush[1]),
    .sr_mode(sr_mode[1]), .sr_din(sr_din[1]), .sr_dout(sr_dout[1]),
    .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]), .busy(busy[1]), .done(done[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // {mode, ser_valid, done, busy, in_ready}
  function automatic logic [5:0] outs(input int i);
    return {sr_mode[i], ser_valid[i], done[i], busy[i], in_ready[i]};
  endfunction

  task automatic accept(input int idx, input logic [W-1:0] data, input logic msb,
                        input logic fl, input logic keep);
    int n = 0;
    while (!in_ready[idx] && n < 50) begin
      tick;
      n++;
    end
    chk("wait_ready", {31'd0, in_ready[idx]}, 32'd1);
    in_valid[idx]  = 1'b1;
    in_data[idx]   = data;
    msb_first[idx] = msb;
    flush[idx]     = fl;
    t_acc[idx]     = cyc_n;
    tick;
    flush[idx] = 1'b0;
    if (!keep) in_valid[idx] = 1'b0;
  endtask

  // Expected trace per word: one LOAD cycle, W shift cycles carrying the word
  // in the chosen order with done on the last, gap cycles of hold, then idle.
  task automatic run_word(input int idx, input logic [W-1:0] data, input logic msb,
                          input logic keep, input logic fl, output logic [W-1:0] got);
    int g;
    logic [1:0] sm;
    logic [5:0] exp;
    logic sh;
    g   = (idx == 1) ? G1 : 0;
    got = '0;
    accept(idx, data, msb, fl, keep);
    for (int off = 0; off <= W + g; off++) begin
      sh = (off >= 1) && (off <= W);
      if (off == 0) sm = MODE_LOAD;
      else if (sh) sm = msb ? MODE_SHL : MODE_SHR;
      else sm = MODE_HOLD;
      exp = {sm, sh, (off == W), 1'b1, 1'b0};
      chk("trace", {26'd0, outs(idx)}, {26'd0, exp});
      if (sh) begin
        chk("ser_bit", {31'd0, ser_bit[idx]}, {31'd0, msb ? data[W-off] : data[off-1]});
        got = {got[W-2:0], ser_bit[idx]};
      end
      in_data[idx]   = W'($urandom);
      msb_first[idx] = 1'($urandom);
      tick;
    end
    chk("idle_after", {26'd0, outs(idx)}, {26'd0, MODE_HOLD, 4'b0001});
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         msb;
    logic [W-1:0] stream;   // first bit out at stream[W-1]
  } vec_t;

  vec_t vecs[4];
  logic [W-1:0] got;
  int t_first;

  initial begin
    vecs[0] = '{4'b0111, 1'b1, 4'b0111};
    vecs[1] = '{4'b1010, 1'b0, 4'b0101};
    vecs[2] = '{4'b1001, 1'b0, 4'b1001};
    vecs[3] = '{4'b1100, 1'b0, 4'b0011};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; msb_first[i] = 1'b0; flush[i] = 1'b0;
    end
    #2;
    chk("rst_outs", {26'd0, outs(0)}, {26'd0, MODE_HOLD, 4'b0001});
    chk("rst_din", {28'd0, sr_din[0]}, 32'd0);
    in_valid[0] = 1'b1; in_data[0] = 4'b1111;
    tick; tick;
    chk("rst_no_hs", {26'd0, outs(0)}, {26'd0, MODE_HOLD, 4'b0001});
    in_valid[0] = 1'b0;
    rst = 1'b0;
    tick;

    // Directed vectors.
    foreach (vecs[k]) begin
      run_word(0, vecs[k].data, vecs[k].msb, 1'b0, 1'b0, got);
      chk("vec_stream", {28'd0, got}, {28'd0, vecs[k].stream});
    end

    // Back-to-back with in_valid held high.
    run_word(0, 4'b1100, 1'b1, 1'b1, 1'b0, got);
    t_first = t_acc[0];
    chk("b2b_first", {28'd0, got}, 32'hC);
    run_word(0, 4'b0011, 1'b1, 1'b1, 1'b0, got);
    chk("b2b_second", {28'd0, got}, 32'h3);
    chk("b2b_interval", t_acc[0] - t_first, W + 2);
    in_valid[0] = 1'b0;
    tick;

    // Gap instance, two queued words.
    run_word(1, 4'b1011, 1'b1, 1'b1, 1'b0, got);
    t_first = t_acc[1];
    run_word(1, 4'b0110, 1'b0, 1'b1, 1'b0, got);
    chk("gap_stream", {28'd0, got}, 32'h6);
    chk("gap_interval", t_acc[1] - t_first, W + 2 + G1);
    in_valid[1] = 1'b0;
    tick;

    // Asynchronous reset during the second shift cycle.
    accept(0, 4'b1110, 1'b1, 1'b0, 1'b0);
    tick; tick;
    chk("pre_rst_shift", {26'd0, outs(0)}, {26'd0, MODE_SHL, 4'b1010});
    #1 rst = 1'b1;
    #1 chk("async_rst", {26'd0, outs(0)}, {26'd0, MODE_HOLD, 4'b0001});
    tick; tick; tick;
    chk("rst_no_done", {26'd0, outs(0)}, {26'd0, MODE_HOLD, 4'b0001});
    rst = 1'b0;
    tick;
    run_word(0, 4'b1001, 1'b1, 1'b0, 1'b0, got);
    chk("post_rst_stream", {28'd0, got}, 32'h9);

    // Flush on the second shift cycle, then flush together with acceptance.
    accept(0, 4'b0110, 1'b1, 1'b0, 1'b0);
    tick; tick;
    chk("pre_flush", {26'd0, outs(0)}, {26'd0, MODE_SHL, 4'b1010});
    flush[0] = 1'b1;
    tick;
    flush[0] = 1'b0;
    chk("flush_idle", {26'd0, outs(0)}, {26'd0, MODE_HOLD, 4'b0001});
    run_word(0, 4'b0101, 1'b0, 1'b0, 1'b1, got);
    chk("flush_accept", {28'd0, got}, 32'hA);

    // Flush on the last shift cycle still reports done.
    accept(0, 4'b0011, 1'b0, 1'b0, 1'b0);
    tick; tick; tick; tick;
    chk("last_done", {26'd0, outs(0)}, {26'd0, MODE_SHR, 4'b1110});
    flush[0] = 1'b1;
    tick;
    flush[0] = 1'b0;
    chk("last_flush_idle", {26'd0, outs(0)}, {26'd0, MODE_HOLD, 4'b0001});

    // Flush during the gap.
    accept(1, 4'b0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W + 1; i++) tick;
    chk("in_gap", {26'd0, outs(1)}, {26'd0, MODE_HOLD, 4'b0010});
    flush[1] = 1'b1;
    tick;
    flush[1] = 1'b0;
    chk("gap_flush_idle", {26'd0, outs(1)}, {26'd0, MODE_HOLD, 4'b0001});

    // Randomized words on both instances against the trace model.
    for (int n = 0; n < 40; n++) begin
      int idx;
      int dly;
      idx = n % 2;
      dly = $urandom_range(0, 3);
      if (dly > 0) begin
        in_valid[idx] = 1'b0;
        for (int d = 0; d < dly; d++) tick;
      end
      run_word(idx, W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), got);
      in_valid[idx] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
